// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter sharing one UART transmitter between two byte streams.
// An owner keeps the grant until it sends a byte marked last or stays silent past the timeout.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] grant
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_served_q, last_served_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State register; last_served resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_served_q <= 1'b1;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state, silence counter and combinational pass-through of the owner.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        cnt_d         = cnt_q;
        tx_data       = '0;
        tx_valid      = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        grant         = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req0_valid && req1_valid) begin
                    state_d = last_served_q ? ST_OWN0 : ST_OWN1;
                end else if (req0_valid) begin
                    state_d = ST_OWN0;
                end else if (req1_valid) begin
                    state_d = ST_OWN1;
                end
            end

            ST_OWN0: begin
                tx_data    = req0_data;
                tx_valid   = req0_valid;
                req0_ready = tx_ready;
                grant      = 2'b01;
                if (req0_valid) begin
                    cnt_d = '0;
                    if (tx_ready && req0_last) begin
                        state_d       = ST_IDLE;
                        last_served_d = 1'b0;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b0;
                    cnt_d         = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_OWN1: begin
                tx_data    = req1_data;
                tx_valid   = req1_valid;
                req1_ready = tx_ready;
                grant      = 2'b10;
                if (req1_valid) begin
                    cnt_d = '0;
                    if (tx_ready && req1_last) begin
                        state_d       = ST_IDLE;
                        last_served_d = 1'b1;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b1;
                    cnt_d         = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // No handshake may complete while reset is asserted, even before the state settles.
        if (rst) begin
            tx_valid   = 1'b0;
            req0_ready = 1'b0;
            req1_ready = 1'b0;
            grant      = 2'b00;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus timeout and reset sequences.
module tb_uart_tx_arbiter;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       tr;
        logic [1:0] e_grant;
        logic       e_txv;
        logic [7:0] e_txd;
        logic       e_r0;
        logic       e_r1;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] req0_data, req1_data, tx_data;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic       tx_valid, tx_ready;
    logic [1:0] grant;

    logic [7:0] n_req0_data, n_req1_data, n_tx_data;
    logic       n_req0_valid, n_req0_last, n_req0_ready;
    logic       n_req1_valid, n_req1_last, n_req1_ready;
    logic       n_tx_valid, n_tx_ready;
    logic [1:0] n_grant;

    int n_checks = 0;
    int n_errors = 0;
    vec_t tbl[$];

    uart_tx_arbiter #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk(clk), .rst(rst),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .grant(grant)
    );

    uart_tx_arbiter #(.TIMEOUT_CYCLES(0)) u_dut_nto (
        .clk(clk), .rst(rst),
        .req0_data(n_req0_data), .req0_valid(n_req0_valid), .req0_last(n_req0_last), .req0_ready(n_req0_ready),
        .req1_data(n_req1_data), .req1_valid(n_req1_valid), .req1_last(n_req1_last), .req1_ready(n_req1_ready),
        .tx_data(n_tx_data), .tx_valid(n_tx_valid), .tx_ready(n_tx_ready), .grant(n_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t v(input logic r,
                               input logic vv0, input logic [7:0] dd0, input logic ll0,
                               input logic vv1, input logic [7:0] dd1, input logic ll1,
                               input logic trr, input logic [1:0] g, input logic tv,
                               input logic [7:0] td, input logic rr0, input logic rr1);
        vec_t t;
        t.rst = r;   t.v0 = vv0; t.d0 = dd0; t.l0 = ll0;
        t.v1 = vv1;  t.d1 = dd1; t.l1 = ll1; t.tr = trr;
        t.e_grant = g; t.e_txv = tv; t.e_txd = td; t.e_r0 = rr0; t.e_r1 = rr1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then let the edge commit.
    task automatic step(input vec_t t, input string tag);
        rst = t.rst;
        req0_valid = t.v0; req0_data = t.d0; req0_last = t.l0;
        req1_valid = t.v1; req1_data = t.d1; req1_last = t.l1;
        tx_ready = t.tr;
        @(negedge clk);
        chk($sformatf("%s grant", tag), 8'(grant), 8'(t.e_grant));
        chk($sformatf("%s tx_valid", tag), 8'(tx_valid), 8'(t.e_txv));
        chk($sformatf("%s req0_ready", tag), 8'(req0_ready), 8'(t.e_r0));
        chk($sformatf("%s req1_ready", tag), 8'(req1_ready), 8'(t.e_r1));
        if (!t.rst) chk($sformatf("%s tx_data", tag), tx_data, t.e_txd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_data = '0; req0_valid = 1'b0; req0_last = 1'b0;
        req1_data = '0; req1_valid = 1'b0; req1_last = 1'b0;
        tx_ready = 1'b0;
        n_req0_data = '0; n_req0_valid = 1'b0; n_req0_last = 1'b0;
        n_req1_data = '0; n_req1_valid = 1'b0; n_req1_last = 1'b0;
        n_tx_ready = 1'b0;

        //          rst v0 d0     l0 v1 d1     l1 tr  grant  txv txd    r0 r1
        tbl.push_back(v(1, 1, 8'h48, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(v(1, 1, 8'h48, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h48, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h48, 0, 0, 8'h00, 0, 1, 2'b01, 1, 8'h48, 1, 0));
        tbl.push_back(v(0, 1, 8'h69, 0, 0, 8'h00, 0, 1, 2'b01, 1, 8'h69, 1, 0));
        tbl.push_back(v(0, 1, 8'h0A, 1, 0, 8'h00, 0, 1, 2'b01, 1, 8'h0A, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0));
        // Contention: requester 0 was served last, so requester 1 goes first.
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b10, 1, 8'hB0, 0, 1));
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB1, 1, 1, 2'b10, 1, 8'hB1, 0, 1));
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b01, 1, 8'hA0, 1, 0));
        tbl.push_back(v(0, 1, 8'hA1, 1, 1, 8'hB0, 0, 1, 2'b01, 1, 8'hA1, 1, 0));
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b10, 1, 8'hB0, 0, 1));
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB1, 1, 1, 2'b10, 1, 8'hB1, 0, 1));
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b01, 1, 8'hA0, 1, 0));
        tbl.push_back(v(0, 1, 8'hA1, 1, 1, 8'hB0, 0, 1, 2'b01, 1, 8'hA1, 1, 0));
        // Backpressure on requester 1 with tx_ready 1,0,0,1 while requester 0 waits.
        tbl.push_back(v(0, 1, 8'hA0, 1, 1, 8'hC0, 0, 0, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'hA0, 1, 1, 8'hC0, 0, 1, 2'b10, 1, 8'hC0, 0, 1));
        tbl.push_back(v(0, 1, 8'hA0, 1, 1, 8'hC1, 1, 0, 2'b10, 1, 8'hC1, 0, 0));
        tbl.push_back(v(0, 1, 8'hA0, 1, 1, 8'hC1, 1, 0, 2'b10, 1, 8'hC1, 0, 0));
        tbl.push_back(v(0, 1, 8'hA0, 1, 1, 8'hC1, 1, 1, 2'b10, 1, 8'hC1, 0, 1));
        tbl.push_back(v(0, 1, 8'hA0, 1, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'hA0, 1, 0, 8'h00, 0, 1, 2'b01, 1, 8'hA0, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Timeout: requester 0 goes silent after 0x55; grant held 9 silent cycles, then released.
        step(v(0, 1, 8'h55, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0), "to_req");
        step(v(0, 1, 8'h55, 0, 1, 8'h77, 1, 1, 2'b01, 1, 8'h55, 1, 0), "to_byte");
        for (int k = 0; k <= 8; k++)
            step(v(0, 0, 8'h00, 0, 1, 8'h77, 1, 1, 2'b01, 0, 8'h00, 1, 0), $sformatf("to_silent%0d", k));
        step(v(0, 0, 8'h00, 0, 1, 8'h77, 1, 1, 2'b00, 0, 8'h00, 0, 0), "to_idle");
        step(v(0, 0, 8'h00, 0, 1, 8'h77, 1, 1, 2'b10, 1, 8'h77, 0, 1), "to_next");
        step(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0), "to_done");

        // Valid returns exactly when the counter reaches the limit: no release.
        step(v(0, 1, 8'h66, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0), "bd_req");
        step(v(0, 1, 8'h66, 0, 0, 8'h00, 0, 1, 2'b01, 1, 8'h66, 1, 0), "bd_byte");
        for (int k = 0; k < 8; k++)
            step(v(0, 0, 8'h00, 0, 1, 8'h77, 1, 1, 2'b01, 0, 8'h00, 1, 0), $sformatf("bd_silent%0d", k));
        step(v(0, 1, 8'h67, 1, 1, 8'h77, 1, 0, 2'b01, 1, 8'h67, 0, 0), "bd_edge");
        step(v(0, 1, 8'h67, 1, 1, 8'h77, 1, 1, 2'b01, 1, 8'h67, 1, 0), "bd_accept");
        step(v(0, 0, 8'h00, 0, 1, 8'h77, 1, 1, 2'b00, 0, 8'h00, 0, 0), "bd_idle");
        step(v(0, 0, 8'h00, 0, 1, 8'h77, 1, 1, 2'b10, 1, 8'h77, 0, 1), "bd_next");

        // Serve requester 0 so a surviving last_served would favour requester 1 after reset.
        step(v(0, 1, 8'h5A, 1, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0), "pre_req");
        step(v(0, 1, 8'h5A, 1, 0, 8'h00, 0, 1, 2'b01, 1, 8'h5A, 1, 0), "pre_byte");

        // Reset in the middle of a requester 1 message.
        step(v(0, 0, 8'h00, 0, 1, 8'hE0, 0, 1, 2'b00, 0, 8'h00, 0, 0), "rm_req");
        step(v(0, 0, 8'h00, 0, 1, 8'hE0, 0, 1, 2'b10, 1, 8'hE0, 0, 1), "rm_byte0");
        step(v(1, 0, 8'h00, 0, 1, 8'hE1, 0, 1, 2'b00, 0, 8'h00, 0, 0), "rm_rst0");
        step(v(1, 1, 8'hA5, 1, 1, 8'hE1, 0, 1, 2'b00, 0, 8'h00, 0, 0), "rm_rst1");
        step(v(0, 1, 8'hA5, 1, 1, 8'hE1, 0, 1, 2'b00, 0, 8'h00, 0, 0), "rm_idle");
        step(v(0, 1, 8'hA5, 1, 1, 8'hE1, 0, 1, 2'b01, 1, 8'hA5, 1, 0), "rm_win0");
        step(v(0, 0, 8'h00, 0, 1, 8'hE1, 0, 1, 2'b00, 0, 8'h00, 0, 0), "rm_gap");
        step(v(0, 0, 8'h00, 0, 1, 8'hE1, 0, 1, 2'b10, 1, 8'hE1, 0, 1), "rm_resume1");
        step(v(0, 0, 8'h00, 0, 1, 8'hE2, 1, 1, 2'b10, 1, 8'hE2, 0, 1), "rm_last1");
        step(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0), "rm_done");

        // Timeout disabled: a silent owner keeps the grant indefinitely.
        n_req0_valid = 1'b1; n_req0_data = 8'h31; n_req0_last = 1'b0; n_tx_ready = 1'b1;
        @(negedge clk);
        chk("nto idle grant", 8'(n_grant), 8'h00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nto own grant", 8'(n_grant), 8'h01);
        chk("nto own tx_valid", 8'(n_tx_valid), 8'h01);
        chk("nto own tx_data", n_tx_data, 8'h31);
        @(posedge clk); #1;
        n_req0_valid = 1'b0; n_req0_data = 8'h00;
        n_req1_valid = 1'b1; n_req1_data = 8'h99; n_req1_last = 1'b1;
        for (int c = 1; c <= 5000; c++) begin
            @(negedge clk);
            if ((c % 1000) == 0) begin
                chk($sformatf("nto held%0d grant", c), 8'(n_grant), 8'h01);
                chk($sformatf("nto held%0d tx_valid", c), 8'(n_tx_valid), 8'h00);
                chk($sformatf("nto held%0d req1_ready", c), 8'(n_req1_ready), 8'h00);
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
